// File: rtl/pcie_up_mrd_tag_ctrl_if.sv
// Handshake bundle between the user read engine, the MRd TLP builder and the
// reorder-buffer return path of pcie_up_mrd_tag_ctrl.
// master: the surroundings (user logic, TX builder, reorder buffer).
// slave : the tag controller itself.
interface pcie_up_mrd_tag_ctrl_if;
   logic        USR_RD_REQ;
   logic [31:0] USR_RD_ADDR;
   logic [15:0] USR_RD_LEN;
   logic        USR_RD_BUSY;
   logic        USR_RD_DONE;
   logic        MRD_REQ;
   logic        MRD_ACK;
   logic [31:0] MRD_ADDR;
   logic [7:0]  MRD_TAG;
   logic [9:0]  MRD_DWLEN;
   logic        DN_CX_EOP;
   logic [6:0]  OUTS_CNT;

   modport master (
      output USR_RD_REQ, USR_RD_ADDR, USR_RD_LEN, MRD_ACK, DN_CX_EOP,
      input  USR_RD_BUSY, USR_RD_DONE, MRD_REQ, MRD_ADDR, MRD_TAG, MRD_DWLEN, OUTS_CNT
   );

   modport slave (
      input  USR_RD_REQ, USR_RD_ADDR, USR_RD_LEN, MRD_ACK, DN_CX_EOP,
      output USR_RD_BUSY, USR_RD_DONE, MRD_REQ, MRD_ADDR, MRD_TAG, MRD_DWLEN, OUTS_CNT
   );
endinterface

// File: rtl/pcie_up_mrd_tag_ctrl.sv
// Upstream MRd tag controller: splits a user read into 128-byte MRd requests,
// hands out reorder-buffer slots as tags and throttles on outstanding count.
module pcie_up_mrd_tag_ctrl #(
   parameter int unsigned P_MAX_OUTS = 32
) (
   input  logic                          PCIE_CLK,
   input  logic                          PCIE_RST_N,
   pcie_up_mrd_tag_ctrl_if.slave         io_bus
);

   localparam logic [6:0] LP_MAX_OUTS = 7'(P_MAX_OUTS);

   typedef enum logic [4:0] {
      StIdle = 5'b00001,
      StChek = 5'b00010,
      StIssu = 5'b00100,
      StWait = 5'b01000,
      StDone = 5'b10000
   } state_e;

   state_e      r_state;
   logic [24:0] r_addr;      // 128-byte block address, bits [31:7]
   logic [5:0]  r_tag;       // reorder-buffer slot, never cleared between commands
   logic [8:0]  r_remain;
   logic        r_mrd_req;
   logic        r_busy;
   logic        r_done;
   logic [6:0]  r_outs;

   logic [8:0]  w_blocks;
   logic        w_accept;
   logic        w_eop;
   logic        w_room;
   logic        w_unused_bits;

   assign w_blocks      = io_bus.USR_RD_LEN[15:7];
   assign w_accept      = r_mrd_req & io_bus.MRD_ACK;
   // An EOP with nothing outstanding is stale and must not underflow.
   assign w_eop         = io_bus.DN_CX_EOP & (r_outs != 7'd0);
   assign w_room        = (r_outs < LP_MAX_OUTS);
   assign w_unused_bits = ^{io_bus.USR_RD_ADDR[6:0], io_bus.USR_RD_LEN[6:0]};

   // Command sequencing FSM with registered request/busy/done outputs.
   always_ff @(posedge PCIE_CLK) begin
      if (!PCIE_RST_N) begin
         r_state   <= StIdle;
         r_addr    <= 25'd0;
         r_tag     <= 6'd0;
         r_remain  <= 9'd0;
         r_mrd_req <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.USR_RD_REQ) begin
                  r_busy <= 1'b1;
                  if (w_blocks == 9'd0) begin
                     r_done  <= 1'b1;
                     r_state <= StDone;
                  end else begin
                     r_addr   <= io_bus.USR_RD_ADDR[31:7];
                     r_remain <= w_blocks;
                     r_state  <= StChek;
                  end
               end
            end
            StChek: begin
               if (w_room) begin
                  r_mrd_req <= 1'b1;
                  r_state   <= StIssu;
               end
            end
            StIssu: begin
               if (w_accept) begin
                  r_mrd_req <= 1'b0;
                  r_addr    <= r_addr + 25'd1;
                  r_tag     <= r_tag + 6'd1;
                  r_remain  <= r_remain - 9'd1;
                  r_state   <= (r_remain == 9'd1) ? StWait : StChek;
               end
            end
            StWait: begin
               if (r_outs == 7'd0) begin
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_mrd_req <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_state   <= StIdle;
            end
         endcase
      end
   end

   // Outstanding-request counter: up on accept, down on a valid EOP.
   always_ff @(posedge PCIE_CLK) begin
      if (!PCIE_RST_N) begin
         r_outs <= 7'd0;
      end else if (w_accept && !w_eop) begin
         r_outs <= r_outs + 7'd1;
      end else if (!w_accept && w_eop) begin
         r_outs <= r_outs - 7'd1;
      end
   end

   assign io_bus.MRD_REQ     = r_mrd_req;
   assign io_bus.MRD_ADDR    = {r_addr, 7'd0};
   assign io_bus.MRD_TAG     = {2'b00, r_tag};
   assign io_bus.MRD_DWLEN   = 10'd32;
   assign io_bus.USR_RD_BUSY = r_busy;
   assign io_bus.USR_RD_DONE = r_done;
   assign io_bus.OUTS_CNT    = r_outs;

endmodule

// File: doc/pcie_up_mrd_tag_ctrl.md
PCIE_UP_MRD_TAG_CTRL -- requirements
Module: pcie_up_mrd_tag_ctrl

Interface
REQ-001 SHALL have parameter P_MAX_OUTS, default 32, max outstanding 128-byte MRd requests (legal 1..64).
REQ-002 SHALL have port PCIE_CLK, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port PCIE_RST_N, input, 1, synchronous active-low reset.
REQ-004 SHALL have port USR_RD_REQ, input, 1, user read command strobe, sampled in IDLE only.
REQ-005 SHALL have port USR_RD_ADDR, input, 32, byte start address; bits [6:0] ignored (128-byte aligned).
REQ-006 SHALL have port USR_RD_LEN, input, 16, byte length; bits [6:0] ignored; block count N = LEN[15:7].
REQ-007 SHALL have port USR_RD_BUSY, output, 1, high from command accept until DONE pulse.
REQ-008 SHALL have port USR_RD_DONE, output, 1, one-cycle pulse when all N blocks are issued and returned.
REQ-009 SHALL have port MRD_REQ, output, 1, MRd request valid to TX TLP builder.
REQ-010 SHALL have port MRD_ACK, input, 1, TX builder accepts current request when MRD_REQ & MRD_ACK.
REQ-011 SHALL have port MRD_ADDR, output, 32, request address, [6:0] = 0.
REQ-012 SHALL have port MRD_TAG, output, 8, request tag; [7:6] = 0, [5:0] = reorder-buffer slot.
REQ-013 SHALL have port MRD_DWLEN, output, 10, constant 10'd32 (128 bytes).
REQ-014 SHALL have port DN_CX_EOP, input, 1, reorder-buffer read EOP; each pulse frees one slot.
REQ-015 SHALL have port OUTS_CNT, output, 7, current outstanding request count (0..64).

Function
REQ-016 SHALL implement FSM states IDLE, CHEK, ISSU, WAIT, DONE (one-hot).
REQ-017 IDLE: on USR_RD_REQ with N>0 latch address/N, set BUSY, go CHEK; with N=0 go DONE directly.
REQ-018 CHEK: if OUTS_CNT < P_MAX_OUTS go ISSU, else stay CHEK.
REQ-019 ISSU: assert MRD_REQ with stable ADDR/TAG until MRD_ACK; on accept, address += 128, tag += 1, remaining -= 1.
REQ-020 ISSU exit on accept: remaining becomes 0 -> WAIT; else -> CHEK.
REQ-021 WAIT: when OUTS_CNT = 0 go DONE; DONE pulses USR_RD_DONE for one cycle, clears BUSY, returns IDLE.
REQ-022 MRD_REQ SHALL be registered; first MRD_REQ appears 2 cycles after USR_RD_REQ sample (IDLE->CHEK->ISSU).
REQ-023 Tag counter SHALL be 6-bit, wrap 63->0, and persist across commands (not reset per command), preserving in-order slot use by the reorder buffer.
REQ-024 OUTS_CNT: +1 on MRd accept, -1 on DN_CX_EOP; simultaneous accept and EOP leaves it unchanged.
REQ-025 DN_CX_EOP while OUTS_CNT = 0 SHALL be ignored (no underflow) and counter stays 0.
REQ-026 Address SHALL increment modulo 2^32; wrap past 0xFFFF_FF80 goes to 0x0000_0000.
REQ-027 USR_RD_REQ outside IDLE SHALL be ignored.
REQ-028 MRD_REQ SHALL never be asserted when OUTS_CNT >= P_MAX_OUTS at the CHEK decision.

Reset
REQ-029 On PCIE_RST_N low at a clock edge: FSM = IDLE, MRD_REQ = 0, MRD_ADDR = 0, MRD_TAG = 0, OUTS_CNT = 0, USR_RD_BUSY = 0, USR_RD_DONE = 0, remaining = 0; MRD_DWLEN stays 10'd32.
REQ-030 Reset mid-command SHALL abandon the command; no DONE pulse; late DN_CX_EOP after reset is ignored per REQ-025.

Verification
REQ-031 ADDR=0x1000_0000, LEN=0x0200, MRD_ACK tied high, EOP 10 cycles after each accept -> 4 MRd at 0x1000_0000/0080/0100/0180 tags 0..3, then single DONE pulse, BUSY low.
REQ-032 P_MAX_OUTS=2, LEN=0x0400, no EOP -> exactly 2 MRd issued, FSM holds CHEK, OUTS_CNT=2; each EOP releases one more MRd.
REQ-033 Second command after 62 tags used, LEN=0x0200 -> tags 62, 63, 0, 1.
REQ-034 LEN=0x007F -> no MRd, DONE pulse 1 cycle after IDLE accept, BUSY high 1 cycle.
REQ-035 Accept and DN_CX_EOP in same cycle with OUTS_CNT=5 -> OUTS_CNT stays 5; MRD_ACK held low 20 cycles -> MRD_REQ/ADDR/TAG stable throughout.
REQ-036 Reset asserted in ISSU with OUTS_CNT=3 -> next cycle all outputs per REQ-029; following EOP pulses leave OUTS_CNT at 0.
